mc_main_controller: RTL and testbench
=====================================

// Module: mc_main_controller
// PURPOSE
//  Moore FSM sequencing the multi-cycle datapath: fetch, decode, execute, memory, writeback.
//  Drives the 4-bit ALUOp consumed by the ALU control decoder, plus every mux select and enable.
//  Holds fetch and memory states on a ready handshake; sits between the IR opcode field and the datapath.
// PARAMETERS
//  MEM_HANDSHAKE  1  1: FETCH/MEMRD/MEMWR hold until mem_ready=1; 0: mem_ready ignored, one cycle each
//  IRQ_ILLEGAL    1  1: pulse illegal_op on unknown opcode; 0: illegal_op tied 0
// PORTS
//  clk          in   1  rising-edge clock
//  rst_n        in   1  asynchronous active-low reset
//  opcode       in   6  IR[31:26]; stable from the cycle after IRWrite
//  funct        in   6  IR[5:0]
//  mem_ready    in   1  memory completes the access presented this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load qualified by ALU Zero (beq)
//  IorD         out  1  0: address=PC, 1: address=ALUOut
//  MemRead      out  1  memory read request
//  MemWrite     out  1  memory write request
//  IRWrite      out  1  IR load (with MDR)
//  RegWrite     out  1  register file write
//  RegDst       out  2  00 rt, 01 rd, 10 $31
//  MemtoReg     out  2  00 ALUOut, 01 MDR, 10 PC
//  ALUSrcA      out  2  00 PC, 01 A, 10 shamt
//  ALUSrcB      out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
//  PCSource     out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A
//  ExtOp        out  1  1: sign-extend imm, 0: zero-extend
//  LuiOp        out  1  imm<<16 selected
//  ALUOp        out  4  [3]=1 unsigned; [2:0] 000 add, 001 sub, 100 and, 101 slt, 010 use funct
//  illegal_op   out  1  one-cycle pulse in DECODE on an unsupported opcode
//  state_dbg    out  4  current state encoding
// BEHAVIOUR
//  States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEMADDR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP, RWB, IWB.
//  Reset: rst_n=0 forces IDLE asynchronously, also mid-instruction; all outputs 0 in IDLE.
//  IDLE -> FETCH on the first clk edge with rst_n=1.
//  FETCH: MemRead, IRWrite, PCWrite, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=0000, PCSource=00.
//  FETCH holds while MEM_HANDSHAKE && !mem_ready; IRWrite/PCWrite are asserted only in the ready cycle.
//  DECODE: ALUSrcA=00, ALUSrcB=11, ALUOp=0000 (branch target into ALUOut); next state by opcode:
//   0x00 -> EXEC_R except funct 0x08/0x09 -> JUMP; 0x23/0x2b -> MEMADDR; 0x04 -> BRANCH;
//   0x02/0x03 -> JUMP; 0x08,0x09,0x0a,0x0b,0x0c,0x0f -> EXEC_I; other -> FETCH with illegal_op=1.
//  EXEC_R: ALUOp=0010; ALUSrcA=10 for funct 00/02/03, else 01; ALUSrcB=00; -> RWB.
//  RWB: RegWrite, RegDst=01, MemtoReg=00; -> FETCH.
//  EXEC_I: ALUSrcA=01, ALUSrcB=10; ALUOp addi 0000, addiu 1000, andi 0100, slti 0101, sltiu 1101, lui 0000.
//   ExtOp=0 for andi only; LuiOp=1 for lui; -> IWB.
//  IWB: RegWrite, RegDst=00, MemtoReg=00; -> FETCH.
//  MEMADDR: ALUSrcA=01, ALUSrcB=10, ExtOp=1, ALUOp=0000; -> MEMRD (lw) / MEMWR (sw).
//  MEMRD/MEMWR: IorD=1, MemRead or MemWrite held until ready; -> MEMWB / FETCH.
//  MEMWB: RegWrite, RegDst=00, MemtoReg=01; -> FETCH.
//  BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=0001, PCWriteCond, PCSource=01; -> FETCH.
//  JUMP: PCWrite; PCSource=10 (j/jal) or 11 (jr/jalr); jal: RegWrite, RegDst=10, MemtoReg=10;
//   jalr: RegWrite, RegDst=01, MemtoReg=10; -> FETCH.
//  CPI: R/I 4, beq 3, j 3, sw 4, lw 5 at zero wait; +1 per cycle with mem_ready=0.
//  Outputs are combinational from state plus opcode/funct; no output depends on mem_ready except FETCH enables.
// STRUCTURE
//  Shared header mc_ctrl_defs.vh: state encodings, opcode/funct constants, ALUOp encodings,
//   and mux-select encodings (also used by the datapath and ALU control).
//  Sub-module mc_ctrl_decode: combinational opcode/funct -> next-state class and I-type ALUOp/ExtOp/LuiOp.
// TESTING
//  rst_n low 3 cycles then high -> IDLE, then FETCH on the next edge; all outputs 0 during reset.
//  add (op 0x00, funct 0x20), mem_ready=1 -> FETCH,DECODE,EXEC_R,RWB; ALUOp=0010, RegWrite with RegDst=01.
//  lw (0x23), mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles, MemRead and IorD=1 held; 7 cycles total.
//  beq (0x04) -> BRANCH with ALUOp=0001, PCWriteCond=1, PCSource=01; sltiu (0x0b) -> ALUOp=1101, ExtOp=1.
//  jal (0x03) -> JUMP with PCSource=10, RegDst=10, MemtoReg=10, RegWrite=1; jr -> PCSource=11, RegWrite=0.
//  opcode 0x3f -> illegal_op pulse in DECODE, then FETCH; rst_n low in MEMWR -> IDLE, MemWrite drops at once.

Source files
------------

// File: rtl/mc_main_controller_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, ALUOp and mux selects.
package mc_main_controller_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FN_W    = 6;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EXEC_R  = 4'd3,
    ST_EXEC_I  = 4'd4,
    ST_MEMADDR = 4'd5,
    ST_MEMRD   = 4'd6,
    ST_MEMWB   = 4'd7,
    ST_MEMWR   = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_JUMP    = 4'd10,
    ST_RWB     = 4'd11,
    ST_IWB     = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_MEM, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL
  } class_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0a;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h0b;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0c;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  localparam logic [FN_W-1:0] FN_SLL  = 6'h00;
  localparam logic [FN_W-1:0] FN_SRL  = 6'h02;
  localparam logic [FN_W-1:0] FN_SRA  = 6'h03;
  localparam logic [FN_W-1:0] FN_JR   = 6'h08;
  localparam logic [FN_W-1:0] FN_JALR = 6'h09;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 4'b0100;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 4'b0101;
  localparam logic [ALUOP_W-1:0] ALU_ADDU  = 4'b1000;
  localparam logic [ALUOP_W-1:0] ALU_SLTU  = 4'b1101;

  localparam logic [SEL_W-1:0] REGDST_RT = 2'b00;
  localparam logic [SEL_W-1:0] REGDST_RD = 2'b01;
  localparam logic [SEL_W-1:0] REGDST_RA = 2'b10;
  localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] M2R_MDR    = 2'b01;
  localparam logic [SEL_W-1:0] M2R_PC     = 2'b10;
  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_A     = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_SHAMT = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_B       = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JTGT   = 2'b10;
  localparam logic [SEL_W-1:0] PCSRC_REG    = 2'b11;

  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic [SEL_W-1:0]   reg_dst;
    logic [SEL_W-1:0]   mem_to_reg;
    logic [SEL_W-1:0]   alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic [SEL_W-1:0]   pc_source;
    logic               ext_op;
    logic               lui_op;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_main_controller_decode.sv
// Opcode/funct classifier: next-state class plus I-type ALUOp, extension and LUI selects.
module mc_main_controller_decode
  import mc_main_controller_pkg::*;
(
  input  logic [OP_W-1:0]    i_opcode,
  input  logic [FN_W-1:0]    i_funct,
  output class_e             o_cls_c,
  output logic [ALUOP_W-1:0] o_imm_alu_op_c,
  output logic               o_ext_op_c,
  output logic               o_lui_op_c
);

  always_comb begin
    o_cls_c        = CLS_ILLEGAL;
    o_imm_alu_op_c = ALU_ADD;
    o_ext_op_c     = 1'b1;
    o_lui_op_c     = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        if (i_funct == FN_JR || i_funct == FN_JALR) o_cls_c = CLS_JUMP;
        else                                        o_cls_c = CLS_R;
      end
      OP_LW, OP_SW: o_cls_c = CLS_MEM;
      OP_BEQ:       o_cls_c = CLS_BRANCH;
      OP_J, OP_JAL: o_cls_c = CLS_JUMP;
      OP_ADDI:      o_cls_c = CLS_I;
      OP_ADDIU: begin
        o_cls_c        = CLS_I;
        o_imm_alu_op_c = ALU_ADDU;
      end
      OP_SLTI: begin
        o_cls_c        = CLS_I;
        o_imm_alu_op_c = ALU_SLT;
      end
      OP_SLTIU: begin
        o_cls_c        = CLS_I;
        o_imm_alu_op_c = ALU_SLTU;
      end
      OP_ANDI: begin
        o_cls_c        = CLS_I;
        o_imm_alu_op_c = ALU_AND;
        o_ext_op_c     = 1'b0;
      end
      OP_LUI: begin
        o_cls_c    = CLS_I;
        o_lui_op_c = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_main_controller.sv
// Moore sequencer for the multi-cycle datapath: fetch, decode, execute, memory, writeback.
module mc_main_controller
  import mc_main_controller_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit IRQ_ILLEGAL   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FN_W-1:0]    funct,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [SEL_W-1:0]   RegDst,
  output logic [SEL_W-1:0]   MemtoReg,
  output logic [SEL_W-1:0]   ALUSrcA,
  output logic [SEL_W-1:0]   ALUSrcB,
  output logic [SEL_W-1:0]   PCSource,
  output logic               ExtOp,
  output logic               LuiOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_e             r_state;
  state_e             w_next_state;
  ctrl_t              w_ctrl;
  class_e             w_cls;
  logic [ALUOP_W-1:0] w_imm_alu_op;
  logic               w_ext_op;
  logic               w_lui_op;
  logic               w_mem_done;

  mc_main_controller_decode u_decode (
    .i_opcode       (opcode),
    .i_funct        (funct),
    .o_cls_c        (w_cls),
    .o_imm_alu_op_c (w_imm_alu_op),
    .o_ext_op_c     (w_ext_op),
    .o_lui_op_c     (w_lui_op)
  );

  assign w_mem_done = !MEM_HANDSHAKE || mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_ctrl       = '0;
    case (r_state)
      ST_IDLE: w_next_state = ST_FETCH;
      ST_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        if (w_mem_done) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_next_state    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Branch target PC + (sext(imm) << 2) lands in ALUOut for BRANCH.
        w_ctrl.alu_src_b = SRCB_IMM_SH2;
        w_ctrl.ext_op    = 1'b1;
        case (w_cls)
          CLS_R:      w_next_state = ST_EXEC_R;
          CLS_I:      w_next_state = ST_EXEC_I;
          CLS_MEM:    w_next_state = ST_MEMADDR;
          CLS_BRANCH: w_next_state = ST_BRANCH;
          CLS_JUMP:   w_next_state = ST_JUMP;
          default: begin
            w_ctrl.illegal_op = IRQ_ILLEGAL;
            w_next_state      = ST_FETCH;
          end
        endcase
      end
      ST_EXEC_R: begin
        w_ctrl.alu_op    = ALU_FUNCT;
        w_ctrl.alu_src_a = (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA)
                           ? SRCA_SHAMT : SRCA_A;
        w_ctrl.alu_src_b = SRCB_B;
        w_next_state     = ST_RWB;
      end
      ST_RWB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = REGDST_RD;
        w_next_state     = ST_FETCH;
      end
      ST_EXEC_I: begin
        w_ctrl.alu_src_a = SRCA_A;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = w_imm_alu_op;
        w_ctrl.ext_op    = w_ext_op;
        w_ctrl.lui_op    = w_lui_op;
        w_next_state     = ST_IWB;
      end
      ST_IWB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = REGDST_RT;
        w_next_state     = ST_FETCH;
      end
      ST_MEMADDR: begin
        w_ctrl.alu_src_a = SRCA_A;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.ext_op    = 1'b1;
        w_next_state     = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        w_ctrl.iord     = 1'b1;
        w_ctrl.mem_read = 1'b1;
        if (w_mem_done) w_next_state = ST_MEMWB;
      end
      ST_MEMWR: begin
        w_ctrl.iord      = 1'b1;
        w_ctrl.mem_write = 1'b1;
        if (w_mem_done) w_next_state = ST_FETCH;
      end
      ST_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = REGDST_RT;
        w_ctrl.mem_to_reg = M2R_MDR;
        w_next_state      = ST_FETCH;
      end
      ST_BRANCH: begin
        w_ctrl.alu_src_a     = SRCA_A;
        w_ctrl.alu_src_b     = SRCB_B;
        w_ctrl.alu_op        = ALU_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
        w_next_state         = ST_FETCH;
      end
      ST_JUMP: begin
        w_ctrl.pc_write = 1'b1;
        // jr/jalr live under the R-type opcode and jump through register A.
        if (opcode == OP_RTYPE) begin
          w_ctrl.pc_source = PCSRC_REG;
          if (funct == FN_JALR) begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.reg_dst    = REGDST_RD;
            w_ctrl.mem_to_reg = M2R_PC;
          end
        end else begin
          w_ctrl.pc_source = PCSRC_JTGT;
          if (opcode == OP_JAL) begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.reg_dst    = REGDST_RA;
            w_ctrl.mem_to_reg = M2R_PC;
          end
        end
        w_next_state = ST_FETCH;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign PCWrite     = w_ctrl.pc_write;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign IorD        = w_ctrl.iord;
  assign MemRead     = w_ctrl.mem_read;
  assign MemWrite    = w_ctrl.mem_write;
  assign IRWrite     = w_ctrl.ir_write;
  assign RegWrite    = w_ctrl.reg_write;
  assign RegDst      = w_ctrl.reg_dst;
  assign MemtoReg    = w_ctrl.mem_to_reg;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign PCSource    = w_ctrl.pc_source;
  assign ExtOp       = w_ctrl.ext_op;
  assign LuiOp       = w_ctrl.lui_op;
  assign ALUOp       = w_ctrl.alu_op;
  assign illegal_op  = w_ctrl.illegal_op;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_mc_main_controller.sv
// Scoreboard bench: instruction-level model queues expected per-cycle controls, a monitor compares.
module tb_mc_main_controller;
  import mc_main_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic       ExtOp, LuiOp, illegal_op;
  logic [3:0] ALUOp, state_dbg;

  mc_main_controller #(.MEM_HANDSHAKE(1'b1), .IRQ_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ExtOp(ExtOp), .LuiOp(LuiOp), .ALUOp(ALUOp), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mr, mw, irw, rw;
    logic [1:0] rdst, m2r, srca, srcb, pcs;
    logic       ext, lui;
    logic [3:0] aluop;
    logic       ill;
  } obs_t;

  typedef struct packed {
    obs_t v;
    logic ext_dc;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  function automatic obs_t base(input state_e s);
    obs_t o = '0;
    o.st = s;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = state_dbg; o.pcw = PCWrite; o.pcwc = PCWriteCond; o.iord = IorD;
    o.mr = MemRead; o.mw = MemWrite; o.irw = IRWrite; o.rw = RegWrite;
    o.rdst = RegDst; o.m2r = MemtoReg; o.srca = ALUSrcA; o.srcb = ALUSrcB;
    o.pcs = PCSource; o.ext = ExtOp; o.lui = LuiOp; o.aluop = ALUOp; o.ill = illegal_op;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    obs_t a;
    cyc++;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      a = sample();
      if (e.ext_dc) a.ext = e.v.ext;
      checks++;
      if (a !== e.v) begin
        failures++;
        $display("FAIL step cyc=%0d exp_state=%0d got=%07h exp=%07h", cyc, e.v.st, a, e.v);
      end
    end
  end

  task automatic step(input obs_t o, input logic dc);
    exp_t e;
    e.v = o;
    e.ext_dc = dc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b,
                      6'h0c, 6'h0f, 6'h23, 6'h2b};
  endfunction

  task automatic fetch_phase(input int fwait);
    obs_t o;
    for (int w = 0; w < fwait; w++) begin
      mem_ready = 1'b0;
      o = base(ST_FETCH); o.mr = 1'b1; o.srcb = 2'b01;
      step(o, 1'b0);
    end
    mem_ready = 1'b1;
    o = base(ST_FETCH); o.mr = 1'b1; o.irw = 1'b1; o.pcw = 1'b1; o.srcb = 2'b01;
    step(o, 1'b0);
  endtask

  // Reference: what one instruction does cycle by cycle, straight from the ISA control table.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fwait, input int mwait);
    obs_t o;
    bit   jreg;
    opcode = op;
    funct  = fn;
    fetch_phase(fwait);
    mem_ready = 1'($urandom);
    o = base(ST_DECODE); o.srcb = 2'b11; o.ill = !is_legal(op);
    step(o, 1'b1);
    if (!is_legal(op)) return;
    jreg = (op == 6'h00) && (fn == 6'h08 || fn == 6'h09);
    mem_ready = 1'($urandom);
    if (op == 6'h00 && !jreg) begin
      o = base(ST_EXEC_R); o.aluop = 4'b0010;
      o.srca = (fn inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b01;
      step(o, 1'b0);
      mem_ready = 1'($urandom);
      o = base(ST_RWB); o.rw = 1'b1; o.rdst = 2'b01;
      step(o, 1'b0);
    end else if (op == 6'h00 || op == 6'h02 || op == 6'h03) begin
      o = base(ST_JUMP); o.pcw = 1'b1; o.pcs = jreg ? 2'b11 : 2'b10;
      if (op == 6'h03) begin o.rw = 1'b1; o.rdst = 2'b10; o.m2r = 2'b10; end
      if (jreg && fn == 6'h09) begin o.rw = 1'b1; o.rdst = 2'b01; o.m2r = 2'b10; end
      step(o, 1'b0);
    end else if (op == 6'h04) begin
      o = base(ST_BRANCH); o.srca = 2'b01; o.aluop = 4'b0001; o.pcwc = 1'b1; o.pcs = 2'b01;
      step(o, 1'b0);
    end else if (op == 6'h23 || op == 6'h2b) begin
      o = base(ST_MEMADDR); o.srca = 2'b01; o.srcb = 2'b10; o.ext = 1'b1;
      step(o, 1'b0);
      for (int w = 0; w <= mwait; w++) begin
        mem_ready = (w == mwait);
        o = base(op == 6'h23 ? ST_MEMRD : ST_MEMWR); o.iord = 1'b1;
        if (op == 6'h23) o.mr = 1'b1; else o.mw = 1'b1;
        step(o, 1'b0);
      end
      if (op == 6'h23) begin
        mem_ready = 1'($urandom);
        o = base(ST_MEMWB); o.rw = 1'b1; o.m2r = 2'b01;
        step(o, 1'b0);
      end
    end else begin
      o = base(ST_EXEC_I); o.srca = 2'b01; o.srcb = 2'b10;
      case (op)
        6'h09:   o.aluop = 4'b1000;
        6'h0a:   o.aluop = 4'b0101;
        6'h0b:   o.aluop = 4'b1101;
        6'h0c:   o.aluop = 4'b0100;
        default: o.aluop = 4'b0000;
      endcase
      o.ext = (op != 6'h0c);
      o.lui = (op == 6'h0f);
      step(o, 1'b0);
      mem_ready = 1'($urandom);
      o = base(ST_IWB); o.rw = 1'b1;
      step(o, 1'b0);
    end
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [5:0] op_pool [12];
    logic [5:0] fn_pool [11];
    logic [5:0] op, fn;
    op_pool = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b,
                6'h0c, 6'h0f, 6'h23, 6'h2b};
    fn_pool = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02,
                6'h03, 6'h08, 6'h09};
    rst_n = 1'b0; opcode = '0; funct = '0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(base(ST_IDLE), 1'b0);
    rst_n = 1'b1;
    step(base(ST_IDLE), 1'b0);

    run_instr(6'h00, 6'h20, 0, 0);   // add
    run_instr(6'h23, 6'h00, 0, 2);   // lw with two wait cycles in MEMRD
    run_instr(6'h04, 6'h11, 1, 0);   // beq
    run_instr(6'h0b, 6'h05, 0, 0);   // sltiu
    run_instr(6'h03, 6'h08, 0, 0);   // jal
    run_instr(6'h00, 6'h08, 0, 0);   // jr
    run_instr(6'h3f, 6'h00, 0, 0);   // illegal
    run_instr(6'h00, 6'h09, 0, 0);   // jalr
    run_instr(6'h0f, 6'h00, 0, 0);   // lui
    run_instr(6'h0c, 6'h00, 0, 0);   // andi
    run_instr(6'h2b, 6'h00, 2, 1);   // sw with waits

    for (int n = 0; n < 80; n++) begin
      int r;
      r = int'($urandom_range(0, 15));
      op = (r < 12) ? op_pool[r] : 6'($urandom_range(0, 63));
      if (op == 6'h00 && ($urandom_range(0, 3) != 0)) fn = fn_pool[$urandom_range(0, 10)];
      else                                             fn = 6'($urandom_range(0, 63));
      run_instr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    // sw interrupted by reset while MEMWR waits for memory
    opcode = 6'h2b; funct = 6'h00;
    fetch_phase(0);
    begin
      obs_t o;
      o = base(ST_DECODE); o.srcb = 2'b11;
      step(o, 1'b1);
      o = base(ST_MEMADDR); o.srca = 2'b01; o.srcb = 2'b10; o.ext = 1'b1;
      step(o, 1'b0);
      mem_ready = 1'b0;
      o = base(ST_MEMWR); o.iord = 1'b1; o.mw = 1'b1;
      sb_q.push_back('{v: o, ext_dc: 1'b0});
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_memwrite", 32'(MemWrite), 32'd0);
    check("async_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("async_rst_outputs", 32'(sample()), 32'(base(ST_IDLE)));
    @(posedge clk);
    #1;
    step(base(ST_IDLE), 1'b0);
    rst_n = 1'b1;
    step(base(ST_IDLE), 1'b0);
    run_instr(6'h00, 6'h2a, 0, 0);   // slt after recovery

    @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
